execute_md_stage: RTL and testbench

//  Next-generation EX stage: ALU, EX/MEM and MEM/WB forwarding, and destination-register select, plus a
//  non-blocking iterative multiply/divide unit with HI/LO registers. Sits between the ID/EX latch and the MEM stage.

---
 rtl/execute_md_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_execute_md_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md_stage.sv
// EX stage: operand forwarding, ALU, destination select and the EX/MEM latch, plus a
// non-blocking iterative multiply/divide unit that owns the HI/LO registers.
module execute_md_stage #(
    parameter int NB_DATA    = 32,
    parameter int NB_REG     = 5,
    parameter int NB_M_CTRL  = 6,
    parameter int NB_WB_CTRL = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [3:0]            i_alu_op,
    input  logic [2:0]            i_md_op,
    input  logic                  i_src_a_shamt,
    input  logic                  i_src_b_imm,
    input  logic [1:0]            i_reg_dst,
    input  logic [NB_DATA-1:0]    i_data_ra,
    input  logic [NB_DATA-1:0]    i_data_rb,
    input  logic [NB_DATA-1:0]    i_data_inm,
    input  logic [NB_REG-1:0]     i_shamt,
    input  logic [NB_REG-1:0]     i_rs,
    input  logic [NB_REG-1:0]     i_rt,
    input  logic [NB_REG-1:0]     i_rd,
    input  logic [NB_REG-1:0]     i_ex_mem_wreg,
    input  logic                  i_ex_mem_we,
    input  logic [NB_REG-1:0]     i_mem_wb_wreg,
    input  logic                  i_mem_wb_we,
    input  logic [NB_DATA-1:0]    i_ex_mem_result,
    input  logic [NB_DATA-1:0]    i_mem_wb_data,
    input  logic [NB_M_CTRL-1:0]  i_m_ctrl,
    input  logic [NB_WB_CTRL-1:0] i_wb_ctrl,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [NB_M_CTRL-1:0]  o_m_ctrl,
    output logic [NB_WB_CTRL-1:0] o_wb_ctrl,
    output logic [NB_REG-1:0]     o_write_register,
    output logic [NB_DATA-1:0]    o_result,
    output logic [NB_DATA-1:0]    o_data_write_mem
);

    localparam int SH = $clog2(NB_DATA);

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4,  ALU_NOR = 4'd5,  ALU_SLT = 4'd6,  ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8,  ALU_SRL = 4'd9,  ALU_SRA = 4'd10, ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_PASSB = 4'd15;

    localparam logic [2:0] MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV  = 3'd3, MD_DIVU = 3'd4;
    localparam logic [2:0] MD_MFHI = 3'd5, MD_MFLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} md_state_e;

    function automatic logic [NB_DATA-1:0] cond_neg(input logic [NB_DATA-1:0] x, input logic neg);
        return neg ? (~x + NB_DATA'(1)) : x;
    endfunction

    function automatic logic [2*NB_DATA-1:0] cond_neg2(input logic [2*NB_DATA-1:0] x, input logic neg);
        return neg ? (~x + (2*NB_DATA)'(1)) : x;
    endfunction

    md_state_e                state_q, state_d;
    logic [SH-1:0]            cnt_q, cnt_d;
    logic                     is_div_q, is_div_d;
    logic                     sign_a_q, sign_a_d;
    logic                     sign_b_q, sign_b_d;
    logic [NB_DATA-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic [2*NB_DATA-1:0]     acc_q, acc_d, acc_step;
    logic [NB_DATA-1:0]       opnd_q, opnd_d;

    logic                     valid_q, valid_d;
    logic [NB_M_CTRL-1:0]     m_ctrl_q, m_ctrl_d;
    logic [NB_WB_CTRL-1:0]    wb_ctrl_q, wb_ctrl_d;
    logic [NB_REG-1:0]        wreg_q, wreg_d;
    logic [NB_DATA-1:0]       result_q, result_d;
    logic [NB_DATA-1:0]       wdata_q, wdata_d;

    logic [NB_DATA-1:0]       fwd_a, fwd_b, op_a, op_b, alu_res;
    logic signed [NB_DATA-1:0] a_s, b_s;
    logic [SH-1:0]            shamt_amt;
    logic [NB_REG-1:0]        wreg_sel;
    logic [NB_DATA:0]         mul_sum, div_shift, div_trial;
    logic                     md_start_op, md_signed, md_accept;

    // Operand select: EX/MEM beats MEM/WB beats the register file; register 0 never forwards.
    always_comb begin
        fwd_a = i_data_ra;
        if (i_mem_wb_we && (i_mem_wb_wreg == i_rs) && (i_mem_wb_wreg != '0)) fwd_a = i_mem_wb_data;
        if (i_ex_mem_we && (i_ex_mem_wreg == i_rs) && (i_ex_mem_wreg != '0)) fwd_a = i_ex_mem_result;
        fwd_b = i_data_rb;
        if (i_mem_wb_we && (i_mem_wb_wreg == i_rt) && (i_mem_wb_wreg != '0)) fwd_b = i_mem_wb_data;
        if (i_ex_mem_we && (i_ex_mem_wreg == i_rt) && (i_ex_mem_wreg != '0)) fwd_b = i_ex_mem_result;
        op_a      = i_src_a_shamt ? {{(NB_DATA-NB_REG){1'b0}}, i_shamt} : fwd_a;
        op_b      = i_src_b_imm ? i_data_inm : fwd_b;
        a_s       = op_a;
        b_s       = op_b;
        shamt_amt = op_a[SH-1:0];
    end

    always_comb begin
        alu_res = '0;
        case (i_alu_op)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_NOR:   alu_res = ~(op_a | op_b);
            ALU_SLT:   alu_res = {{(NB_DATA-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU:  alu_res = {{(NB_DATA-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:   alu_res = op_b << shamt_amt;
            ALU_SRL:   alu_res = op_b >> shamt_amt;
            ALU_SRA:   alu_res = $unsigned(b_s >>> shamt_amt);
            ALU_LUI:   alu_res = op_b << (NB_DATA/2);
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        case (i_reg_dst)
            2'b01:   wreg_sel = i_rd;
            2'b10:   wreg_sel = '1;
            default: wreg_sel = i_rt;
        endcase
    end

    assign md_start_op = (i_md_op == MD_MULT) || (i_md_op == MD_MULTU) ||
                         (i_md_op == MD_DIV)  || (i_md_op == MD_DIVU);
    assign md_signed   = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
    assign o_stall     = i_valid && (i_md_op != 3'd0) && (state_q != IDLE);
    assign md_accept   = i_valid && md_start_op && (state_q == IDLE) && !o_stall;

    // One iteration: acc holds {partial, multiplier} for mul, {remainder, quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (!is_div_q)
            acc_step = {mul_sum, acc_q[NB_DATA-1:1]};
        else if (div_trial[NB_DATA])
            acc_step = {div_shift[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
        else
            acc_step = {div_trial[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        case (state_q)
            IDLE: begin
                if (md_accept) begin
                    sign_a_d = md_signed && fwd_a[NB_DATA-1];
                    sign_b_d = md_signed && fwd_b[NB_DATA-1];
                    is_div_d = (i_md_op == MD_DIV) || (i_md_op == MD_DIVU);
                    acc_d    = {{NB_DATA{1'b0}}, cond_neg(fwd_a, md_signed && fwd_a[NB_DATA-1])};
                    opnd_d   = cond_neg(fwd_b, md_signed && fwd_b[NB_DATA-1]);
                    cnt_d    = SH'(NB_DATA-1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - SH'(1);
            end
            FIX: begin
                // With a zero divisor every trial succeeds, so the remainder half ends up
                // holding the dividend magnitude; re-signing it restores the dividend.
                if (!is_div_q) begin
                    {hi_d, lo_d} = cond_neg2(acc_q, sign_a_q ^ sign_b_q);
                end else if (opnd_q == '0) begin
                    lo_d = '1;
                    hi_d = cond_neg(acc_q[2*NB_DATA-1:NB_DATA], sign_a_q);
                end else begin
                    lo_d = cond_neg(acc_q[NB_DATA-1:0], sign_a_q ^ sign_b_q);
                    hi_d = cond_neg(acc_q[2*NB_DATA-1:NB_DATA], sign_a_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d   = 1'b0;
        m_ctrl_d  = '0;
        wb_ctrl_d = '0;
        wreg_d    = '0;
        result_d  = '0;
        wdata_d   = '0;
        if (i_valid && !o_stall) begin
            valid_d   = 1'b1;
            m_ctrl_d  = i_m_ctrl;
            wb_ctrl_d = i_wb_ctrl;
            wreg_d    = wreg_sel;
            wdata_d   = fwd_b;
            if (i_md_op == MD_MFHI)      result_d = hi_q;
            else if (i_md_op == MD_MFLO) result_d = lo_q;
            else                         result_d = alu_res;
        end
    end

    // EX/MEM boundary and MD control state.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            valid_q   <= 1'b0;
            m_ctrl_q  <= '0;
            wb_ctrl_q <= '0;
            wreg_q    <= '0;
            result_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            valid_q   <= valid_d;
            m_ctrl_q  <= m_ctrl_d;
            wb_ctrl_q <= wb_ctrl_d;
            wreg_q    <= wreg_d;
            result_q  <= result_d;
            wdata_q   <= wdata_d;
        end
    end

    always_ff @(posedge i_clock) begin
        acc_q  <= acc_d;
        opnd_q <= opnd_d;
    end

    assign o_valid          = valid_q;
    assign o_m_ctrl         = m_ctrl_q;
    assign o_wb_ctrl        = wb_ctrl_q;
    assign o_write_register = wreg_q;
    assign o_result         = result_q;
    assign o_data_write_mem = wdata_q;

endmodule

// File: tb/tb_execute_md_stage.sv
// Bench for execute_md_stage: directed scenarios plus randomized instruction streams
// checked against an arithmetic reference model; a 16-bit instance covers the narrow build.
module tb_execute_md_stage;

    localparam int NB = 32;

    typedef struct {
        logic        valid;
        logic [3:0]  alu_op;
        logic [2:0]  md_op;
        logic        sa, sb;
        logic [1:0]  reg_dst;
        logic [31:0] ra, rb, inm, exr, mbd;
        logic [4:0]  shamt, rs, rt, rd, exw, mbw;
        logic        exwe, mbwe;
        logic [5:0]  mc;
        logic [2:0]  wc;
    } instr_t;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid, i_src_a_shamt, i_src_b_imm, i_ex_mem_we, i_mem_wb_we;
    logic [3:0]  i_alu_op;
    logic [2:0]  i_md_op;
    logic [1:0]  i_reg_dst;
    logic [31:0] i_data_ra, i_data_rb, i_data_inm, i_ex_mem_result, i_mem_wb_data;
    logic [4:0]  i_shamt, i_rs, i_rt, i_rd, i_ex_mem_wreg, i_mem_wb_wreg;
    logic [5:0]  i_m_ctrl;
    logic [2:0]  i_wb_ctrl;
    logic        o_stall, o_valid;
    logic [5:0]  o_m_ctrl;
    logic [2:0]  o_wb_ctrl;
    logic [4:0]  o_write_register;
    logic [31:0] o_result, o_data_write_mem;

    logic        s_valid, s_src_b_imm, s_stall, s_ovalid;
    logic [3:0]  s_alu_op;
    logic [2:0]  s_md_op;
    logic [15:0] s_ra, s_rb, s_inm, s_result, s_wdata;
    logic [5:0]  s_m_ctrl;
    logic [2:0]  s_wb_ctrl;
    logic [4:0]  s_wreg;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_busy = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always #5 clk = ~clk;

    execute_md_stage #(.NB_DATA(32), .NB_REG(5), .NB_M_CTRL(6), .NB_WB_CTRL(3)) dut (
        .i_clock(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_alu_op(i_alu_op),
        .i_md_op(i_md_op), .i_src_a_shamt(i_src_a_shamt), .i_src_b_imm(i_src_b_imm),
        .i_reg_dst(i_reg_dst), .i_data_ra(i_data_ra), .i_data_rb(i_data_rb),
        .i_data_inm(i_data_inm), .i_shamt(i_shamt), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_ex_mem_wreg(i_ex_mem_wreg), .i_ex_mem_we(i_ex_mem_we),
        .i_mem_wb_wreg(i_mem_wb_wreg), .i_mem_wb_we(i_mem_wb_we),
        .i_ex_mem_result(i_ex_mem_result), .i_mem_wb_data(i_mem_wb_data),
        .i_m_ctrl(i_m_ctrl), .i_wb_ctrl(i_wb_ctrl), .o_stall(o_stall), .o_valid(o_valid),
        .o_m_ctrl(o_m_ctrl), .o_wb_ctrl(o_wb_ctrl), .o_write_register(o_write_register),
        .o_result(o_result), .o_data_write_mem(o_data_write_mem)
    );

    execute_md_stage #(.NB_DATA(16), .NB_REG(5), .NB_M_CTRL(6), .NB_WB_CTRL(3)) dut16 (
        .i_clock(clk), .i_reset_n(i_reset_n), .i_valid(s_valid), .i_alu_op(s_alu_op),
        .i_md_op(s_md_op), .i_src_a_shamt(1'b0), .i_src_b_imm(s_src_b_imm),
        .i_reg_dst(2'b00), .i_data_ra(s_ra), .i_data_rb(s_rb),
        .i_data_inm(s_inm), .i_shamt(5'd0), .i_rs(5'd1), .i_rt(5'd2), .i_rd(5'd3),
        .i_ex_mem_wreg(5'd0), .i_ex_mem_we(1'b0),
        .i_mem_wb_wreg(5'd0), .i_mem_wb_we(1'b0),
        .i_ex_mem_result(16'd0), .i_mem_wb_data(16'd0),
        .i_m_ctrl(6'd0), .i_wb_ctrl(3'd0), .o_stall(s_stall), .o_valid(s_ovalid),
        .o_m_ctrl(s_m_ctrl), .o_wb_ctrl(s_wb_ctrl), .o_write_register(s_wreg),
        .o_result(s_result), .o_data_write_mem(s_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic instr_t nop();
        instr_t t;
        t.valid = 1'b0; t.alu_op = '0; t.md_op = '0; t.sa = 1'b0; t.sb = 1'b0;
        t.reg_dst = '0; t.ra = '0; t.rb = '0; t.inm = '0; t.exr = '0; t.mbd = '0;
        t.shamt = '0; t.rs = 5'd1; t.rt = 5'd2; t.rd = 5'd3; t.exw = '0; t.mbw = '0;
        t.exwe = 1'b0; t.mbwe = 1'b0; t.mc = '0; t.wc = '0;
        return t;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 8);
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rnd_ins();
        instr_t t;
        int r;
        t = nop();
        t.valid   = ($urandom % 10) != 0;
        t.alu_op  = 4'($urandom % 16);
        r         = int'($urandom % 32);
        t.md_op   = (r >= 26) ? 3'(r - 25) : 3'd0;
        t.sa      = ($urandom % 4) == 0;
        t.sb      = ($urandom % 4) == 0;
        t.reg_dst = 2'($urandom % 4);
        t.ra = rval(); t.rb = rval(); t.inm = rval(); t.exr = rval(); t.mbd = rval();
        t.shamt = 5'($urandom % 32); t.rs = 5'($urandom % 4); t.rt = 5'($urandom % 4);
        t.rd = 5'($urandom % 32); t.exw = 5'($urandom % 4); t.mbw = 5'($urandom % 4);
        t.exwe = 1'($urandom % 2); t.mbwe = 1'($urandom % 2);
        t.mc = 6'($urandom % 64); t.wc = 3'($urandom % 8);
        return t;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf, input instr_t t);
        if (t.exwe && t.exw == r && t.exw != 5'd0) return t.exr;
        if (t.mbwe && t.mbw == r && t.mbw != 5'd0) return t.mbd;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7: return (a < b) ? 32'd1 : 32'd0;
            8: return b << a[4:0];
            9: return b >> a[4:0];
            10: return $unsigned($signed(b) >>> a[4:0]);
            11: return b << 16;
            15: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0; lo = '0;
        if (op == 3'd1) begin
            p = 64'(sa * sb);
            hi = p[63:32]; lo = p[31:0];
        end else if (op == 3'd2) begin
            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == 3'd3) begin
            q = sa / sb; r = sa % sb;
            p = 64'(q); lo = p[31:0];
            p = 64'(r); hi = p[31:0];
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic step(input instr_t t, output logic st);
        logic [31:0] fa, fb, a, b, e_res;
        logic [4:0]  e_wr;
        logic        e_stall, bubble, accept;
        i_valid = t.valid; i_alu_op = t.alu_op; i_md_op = t.md_op;
        i_src_a_shamt = t.sa; i_src_b_imm = t.sb; i_reg_dst = t.reg_dst;
        i_data_ra = t.ra; i_data_rb = t.rb; i_data_inm = t.inm;
        i_shamt = t.shamt; i_rs = t.rs; i_rt = t.rt; i_rd = t.rd;
        i_ex_mem_wreg = t.exw; i_ex_mem_we = t.exwe; i_ex_mem_result = t.exr;
        i_mem_wb_wreg = t.mbw; i_mem_wb_we = t.mbwe; i_mem_wb_data = t.mbd;
        i_m_ctrl = t.mc; i_wb_ctrl = t.wc;
        #1;
        fa = fwd(t.rs, t.ra, t);
        fb = fwd(t.rt, t.rb, t);
        a  = t.sa ? {27'd0, t.shamt} : fa;
        b  = t.sb ? t.inm : fb;
        e_stall = t.valid && (t.md_op != 3'd0) && (m_busy > 0);
        chk("stall", 64'(o_stall), 64'(e_stall));
        st = o_stall;
        bubble = !t.valid || e_stall;
        accept = t.valid && (t.md_op >= 3'd1) && (t.md_op <= 3'd4) && (m_busy == 0);
        if (t.md_op == 3'd5)      e_res = m_hi;
        else if (t.md_op == 3'd6) e_res = m_lo;
        else                      e_res = alu_ref(t.alu_op, a, b);
        e_wr = (t.reg_dst == 2'b01) ? t.rd : (t.reg_dst == 2'b10) ? 5'd31 : t.rt;
        @(posedge clk);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end
        if (accept) begin
            md_ref(t.md_op, fa, fb, p_hi, p_lo);
            m_busy = NB + 1;
        end
        #1;
        chk("valid", 64'(o_valid), 64'(!bubble));
        chk("m_ctrl", 64'(o_m_ctrl), bubble ? 64'd0 : 64'(t.mc));
        chk("wb_ctrl", 64'(o_wb_ctrl), bubble ? 64'd0 : 64'(t.wc));
        chk("wreg", 64'(o_write_register), bubble ? 64'd0 : 64'(e_wr));
        chk("wdata", 64'(o_data_write_mem), bubble ? 64'd0 : 64'(fb));
        if (bubble || t.md_op == 3'd0 || t.md_op == 3'd5 || t.md_op == 3'd6)
            chk("result", 64'(o_result), bubble ? 64'd0 : 64'(e_res));
        @(negedge clk);
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo, output int stalls);
        instr_t t;
        logic   st;
        t = nop(); t.valid = 1'b1; t.md_op = 3'd5;
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            step(t, st);
            if (!st) break;
            stalls++;
        end
        hi = o_result;
        t.md_op = 3'd6;
        step(t, st);
        lo = o_result;
    endtask

    task automatic s_step(input logic [3:0] aop, input logic [2:0] mop, input logic [15:0] ra,
                          input logic [15:0] rb, input logic sb, input logic [15:0] inm,
                          output logic st);
        s_valid = 1'b1; s_alu_op = aop; s_md_op = mop; s_ra = ra; s_rb = rb;
        s_src_b_imm = sb; s_inm = inm;
        #1;
        st = s_stall;
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t      t;
        logic        st;
        logic [31:0] hi, lo;
        int          n;

        t = nop();
        i_reset_n = 1'b0;
        i_valid = 0; i_alu_op = 0; i_md_op = 0; i_src_a_shamt = 0; i_src_b_imm = 0;
        i_reg_dst = 0; i_data_ra = 0; i_data_rb = 0; i_data_inm = 0; i_shamt = 0;
        i_rs = 0; i_rt = 0; i_rd = 0; i_ex_mem_wreg = 0; i_ex_mem_we = 0;
        i_mem_wb_wreg = 0; i_mem_wb_we = 0; i_ex_mem_result = 0; i_mem_wb_data = 0;
        i_m_ctrl = 0; i_wb_ctrl = 0;
        s_valid = 0; s_alu_op = 0; s_md_op = 0; s_ra = 0; s_rb = 0; s_src_b_imm = 0; s_inm = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_result", 64'(o_result), 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);
        @(negedge clk);
        i_reset_n = 1'b1;

        // Forwarding priority, then register-0 suppression.
        t = nop(); t.valid = 1'b1; t.alu_op = 4'd0; t.rs = 5'd5; t.rt = 5'd6; t.rb = 32'd1;
        t.ra = 32'd100; t.exwe = 1'b1; t.exw = 5'd5; t.exr = 32'd7;
        t.mbwe = 1'b1; t.mbw = 5'd5; t.mbd = 32'd9;
        step(t, st);
        chk("fwd_exmem", 64'(o_result), 64'd8);
        t.exw = 5'd0; t.mbw = 5'd0;
        step(t, st);
        chk("fwd_reg0", 64'(o_result), 64'd101);

        // Signed multiply followed immediately by MFHI/MFLO.
        t = nop(); t.valid = 1'b1; t.md_op = 3'd1; t.ra = 32'hFFFF_FFFE; t.rb = 32'd3;
        step(t, st);
        read_hilo(hi, lo, n);
        chk("mult_stall_cycles", 64'(n), 64'd33);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

        t = nop(); t.valid = 1'b1; t.md_op = 3'd3; t.ra = 32'hFFFF_FFF9; t.rb = 32'd2;
        step(t, st);
        read_hilo(hi, lo, n);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        t = nop(); t.valid = 1'b1; t.md_op = 3'd4; t.ra = 32'd7; t.rb = 32'd0;
        step(t, st);
        read_hilo(hi, lo, n);
        chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(hi), 64'd7);

        // Independent ALU work flows while the MD unit is busy.
        t = nop(); t.valid = 1'b1; t.md_op = 3'd1; t.ra = 32'd5; t.rb = 32'd6;
        step(t, st);
        t = nop(); t.valid = 1'b1; t.alu_op = 4'd0; t.ra = 32'd10; t.rb = 32'd20;
        step(t, st);
        chk("busy_add_nostall", 64'(st), 64'd0);
        chk("busy_add", 64'(o_result), 64'd30);
        t.alu_op = 4'd6; t.ra = 32'hFFFF_FFFF; t.rb = 32'd1;
        step(t, st);
        chk("busy_slt", 64'(o_result), 64'd1);
        t.alu_op = 4'd10; t.sa = 1'b1; t.shamt = 5'd4; t.rb = 32'h8000_0000;
        step(t, st);
        chk("busy_sra", 64'(o_result), 64'hF800_0000);
        read_hilo(hi, lo, n);
        chk("busy_mult_lo", 64'(lo), 64'd30);

        for (int i = 0; i < 800; i++) step(rnd_ins(), st);
        read_hilo(hi, lo, n);

        // Reset in the middle of a multiply.
        t = nop(); t.valid = 1'b1; t.md_op = 3'd1; t.ra = 32'd3; t.rb = 32'd4;
        step(t, st);
        t = nop(); t.valid = 1'b1; t.alu_op = 4'd0; t.ra = 32'd1; t.rb = 32'd1;
        repeat (21) step(t, st);
        i_reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_result", 64'(o_result), 64'd0);
        m_busy = 0; m_hi = '0; m_lo = '0;
        @(posedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;
        read_hilo(hi, lo, n);
        chk("midrst_nostall", 64'(n), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);

        // Narrow build.
        s_step(4'd0, 3'd2, 16'hFFFF, 16'hFFFF, 1'b0, 16'd0, st);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            s_step(4'd0, 3'd5, 16'd0, 16'd0, 1'b0, 16'd0, st);
            if (!st) break;
            n++;
        end
        chk("n16_stall_cycles", 64'(n), 64'd17);
        chk("n16_hi", 64'(s_result), 64'hFFFE);
        s_step(4'd0, 3'd6, 16'd0, 16'd0, 1'b0, 16'd0, st);
        chk("n16_lo", 64'(s_result), 64'h0001);
        s_step(4'd11, 3'd0, 16'd0, 16'd0, 1'b1, 16'h0012, st);
        chk("n16_lui", 64'(s_result), 64'h1200);
        s_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
